// File: rtl/noc_flit_pkg.sv
// rtl/noc_flit_pkg.sv - shared flit field layout, FSM states and flit slice helper
package noc_flit_pkg;

    // Field offsets counted down from the flit MSB
    localparam int FLIT_VALID_POS = 0;
    localparam int FLIT_HEAD_POS  = 1;
    localparam int FLIT_TAIL_POS  = 2;
    localparam int FLIT_VC_POS    = 3;

    localparam int MAX_WORD_W = 256;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    // Flit 1 is the most significant slice; idx 0 selects flit 1
    function automatic logic [MAX_WORD_W-1:0] flit_slice(
        input logic [MAX_WORD_W-1:0] word,
        input int                    flit_w,
        input int                    idx
    );
        logic [MAX_WORD_W-1:0] mask;
        mask = {MAX_WORD_W{1'b1}} >> (MAX_WORD_W - flit_w);
        return (word >> ((3 - idx) * flit_w)) & mask;
    endfunction

endpackage

// File: rtl/packet_word_fifo.sv
// rtl/packet_word_fifo.sv - synchronous wide-word FIFO with full/empty flags
module packet_word_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            if (do_wr && !do_rd)      count <= count + 1'b1;
            else if (!do_wr && do_rd) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/flit_serializer.sv
// rtl/flit_serializer.sv - wide packet word to per-cycle flit stream with per-VC credits
module flit_serializer
    import noc_flit_pkg::*;
#(
    parameter int WIDTH_IN         = 36,
    parameter int FLIT_WIDTH       = WIDTH_IN / 4,
    parameter int VC_ADDRESS_WIDTH = 1,
    parameter int BUFFER_DEPTH     = 8,
    parameter int FIFO_DEPTH       = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [WIDTH_IN-1:0]             data_in,
    input  logic                            valid_in,
    output logic                            ready_out,
    output logic [FLIT_WIDTH-1:0]           flit_out,
    output logic                            flit_valid_out,
    input  logic [2**VC_ADDRESS_WIDTH-1:0]  credit_in
);
    localparam int NUM_VC    = 2**VC_ADDRESS_WIDTH;
    localparam int CW        = $clog2(BUFFER_DEPTH + 1);
    localparam int FAW       = $clog2(FIFO_DEPTH);
    localparam int VALID_BIT = FLIT_WIDTH - 1 - FLIT_VALID_POS;
    localparam int TAIL_BIT  = FLIT_WIDTH - 1 - FLIT_TAIL_POS;
    localparam int VC_MSB    = FLIT_WIDTH - 1 - FLIT_VC_POS;

    logic [WIDTH_IN-1:0]         head;
    logic                        full;
    logic                        empty;
    logic [FAW:0]                fifo_count;
    logic                        wr_ok;
    logic                        pop;
    logic                        emit;
    logic                        next_empty;
    logic [0:0]                  state;
    logic [1:0]                  idx;
    logic [FLIT_WIDTH-1:0]       cur;
    logic [VC_ADDRESS_WIDTH-1:0] cur_vc;
    logic [CW-1:0]               credit [NUM_VC];
    logic [NUM_VC-1:0]           has_credit;

    assign ready_out = !full;
    assign wr_ok     = valid_in && !full;

    packet_word_fifo #(
        .WIDTH (WIDTH_IN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (valid_in),
        .wr_data (data_in),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (fifo_count)
    );

    // The head word is worked on as soon as it lands so a new word reaches flit_out two edges after accept
    always_comb begin
        cur    = FLIT_WIDTH'(flit_slice(MAX_WORD_W'(head), FLIT_WIDTH, int'(idx)));
        cur_vc = cur[VC_MSB -: VC_ADDRESS_WIDTH];
        emit   = !empty && cur[VALID_BIT] && has_credit[cur_vc];
        pop    = !empty && (!cur[VALID_BIT] || (emit && (cur[TAIL_BIT] || idx == 2'd3)));
        next_empty = !wr_ok && (empty || (pop && fifo_count == (FAW+1)'(1)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            idx            <= 2'd0;
            flit_out       <= '0;
            flit_valid_out <= 1'b0;
        end else begin
            state          <= next_empty ? IDLE : SEND;
            flit_valid_out <= emit;
            flit_out       <= emit ? cur : '0;
            if (pop)       idx <= 2'd0;
            else if (emit) idx <= idx + 2'd1;
        end
    end

    for (genvar v = 0; v < NUM_VC; v++) begin : g_credit
        logic [CW-1:0] cnt;
        logic          dec;

        assign dec           = emit && (cur_vc == VC_ADDRESS_WIDTH'(v));
        assign credit[v]     = cnt;
        assign has_credit[v] = (credit[v] != '0);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= CW'(BUFFER_DEPTH);
            end else if (credit_in[v] && !dec) begin
                if (cnt != CW'(BUFFER_DEPTH)) cnt <= cnt + 1'b1;
            end else if (!credit_in[v] && dec) begin
                cnt <= cnt - 1'b1;
            end
        end

`ifndef SYNTHESIS
        always_ff @(posedge clk) begin
            if (rst_n) assert (!(credit_in[v] && !dec && cnt == CW'(BUFFER_DEPTH)));
        end
`endif
    end

endmodule

// File: tb/tb_flit_serializer.sv
// tb/tb_flit_serializer.sv - randomized and directed bench with a flit-stream reference model
module tb_flit_serializer;
    localparam int BD = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [35:0] data_in = '0;
    logic        valid_in = 1'b0;
    logic        ready_out;
    logic [8:0]  flit_out;
    logic        flit_valid_out;
    logic [1:0]  credit_in = '0;

    int          checks = 0;
    int          errors = 0;
    logic [8:0]  exp_q[$];
    int          outstanding[2];
    int          nflits = 0;
    bit          got_v;
    logic [8:0]  got_f;

    flit_serializer #(
        .WIDTH_IN         (36),
        .VC_ADDRESS_WIDTH (1),
        .BUFFER_DEPTH     (BD),
        .FIFO_DEPTH       (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_in        (data_in),
        .valid_in       (valid_in),
        .ready_out      (ready_out),
        .flit_out       (flit_out),
        .flit_valid_out (flit_valid_out),
        .credit_in      (credit_in)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] mkf(input bit v, input bit h, input bit t, input bit vc, input logic [4:0] p);
        return {v, h, t, vc, p};
    endfunction

    // Expected flits of a word: in order, stopping at the first invalid flit or after the tail
    task automatic model_accept(input logic [35:0] w);
        for (int i = 0; i < 4; i++) begin
            logic [8:0] f;
            f = w[35-9*i -: 9];
            if (!f[8]) break;
            exp_q.push_back(f);
            if (f[6]) break;
        end
    endtask

    task automatic step(output bit acc);
        logic [1:0] cr;
        int         vc;
        acc = rst_n && valid_in && ready_out;
        cr  = credit_in;
        if (acc) model_accept(data_in);
        @(posedge clk);
        #1;
        got_v = flit_valid_out;
        got_f = flit_out;
        if (got_v) begin
            nflits++;
            vc = int'(got_f[5]);
            check("credit_avail", (BD - outstanding[vc]) > 0, 1);
            outstanding[vc]++;
            check("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("sb_flit", got_f, exp_q.pop_front());
        end else begin
            check("idle_zero", got_f, 0);
        end
        for (int v = 0; v < 2; v++) if (cr[v]) outstanding[v]--;
        valid_in  = 1'b0;
        credit_in = '0;
    endtask

    task automatic tick();
        bit a;
        step(a);
    endtask

    task automatic send_word(input logic [35:0] w);
        bit a;
        a = 1'b0;
        for (int k = 0; k < 50 && !a; k++) begin
            valid_in = 1'b1;
            data_in  = w;
            step(a);
        end
        if (!a) check("send_timeout", a, 1);
    endtask

    task automatic drain(input bit rc);
        for (int k = 0; k < 300 && exp_q.size() != 0; k++) begin
            if (rc) for (int v = 0; v < 2; v++)
                credit_in[v] = (outstanding[v] > 0) && ($urandom_range(0, 1) == 1);
            tick();
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic return_all();
        for (int k = 0; k < 20 && (outstanding[0] > 0 || outstanding[1] > 0); k++) begin
            credit_in[0] = outstanding[0] > 0;
            credit_in[1] = outstanding[1] > 0;
            tick();
        end
        check("credit_restore0", dut.credit[0], BD - outstanding[0]);
        check("credit_restore1", dut.credit[1], BD - outstanding[1]);
    endtask

    function automatic logic [35:0] rand_word(input bit full4);
        logic [8:0] f[4];
        int         tpos;
        bit         vc;
        vc   = 1'($urandom_range(0, 1));
        tpos = full4 ? 3 : $urandom_range(0, 3);
        for (int i = 0; i < 4; i++) begin
            if (i <= tpos) f[i] = mkf(1'b1, i == 0, i == tpos, vc, 5'($urandom));
            else           f[i] = mkf(1'($urandom_range(0, 1)), 1'b0, 1'b0, vc, 5'($urandom));
        end
        if (!full4 && $urandom_range(0, 7) == 0) f[0][8] = 1'b0;
        return {f[0], f[1], f[2], f[3]};
    endfunction

    initial begin
        logic [35:0] w;
        logic [35:0] words[20];
        bit          a;
        int          base;
        int          wi;
        int          saw_full;

        outstanding[0] = 0;
        outstanding[1] = 0;

        // Reset: valid_in is ignored while reset is held
        w = {mkf(1, 1, 0, 0, 5'h01), mkf(1, 0, 0, 0, 5'h02), mkf(1, 0, 0, 0, 5'h03), mkf(1, 0, 1, 0, 5'h04)};
        for (int k = 0; k < 2; k++) begin
            valid_in = 1'b1;
            data_in  = w;
            tick();
        end
        check("rst_valid", flit_valid_out, 0);
        check("rst_ready", ready_out, 1);
        check("rst_credit0", dut.credit[0], BD);
        rst_n = 1'b1;
        tick();
        check("rst_nothing_out", got_v, 0);

        // Single 4-flit packet
        w = {mkf(1, 1, 0, 0, 5'h1A), mkf(1, 0, 0, 0, 5'h0B), mkf(1, 0, 0, 0, 5'h1C), mkf(1, 0, 1, 0, 5'h0D)};
        valid_in = 1'b1;
        data_in  = w;
        check("t1_ready", ready_out, 1);
        tick();
        check("t1_lat", got_v, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t1_stream", got_v, 1);
        end
        tick();
        check("t1_end", got_v, 0);
        check("t1_credit0", dut.credit[0], BD - 4);
        return_all();

        // Short packets back-to-back
        for (int k = 0; k < 5; k++) begin
            if (k < 3) begin
                check("t2_ready", ready_out, 1);
                valid_in = 1'b1;
                data_in  = {mkf(1, 1, 1, 1'(k), 5'(k + 3)), 27'h5A5A5A5};
            end
            tick();
            check("t2_valid", got_v, (k >= 1 && k <= 3));
        end
        return_all();

        // Credit stall on vc1: use 6 credits first (second word carries junk after its tail)
        send_word({mkf(1, 1, 0, 1, 5'h11), mkf(1, 0, 0, 1, 5'h12), mkf(1, 0, 0, 1, 5'h13), mkf(1, 0, 1, 1, 5'h14)});
        send_word({mkf(1, 1, 0, 1, 5'h15), mkf(1, 0, 1, 1, 5'h16), mkf(1, 0, 0, 1, 5'h1F), mkf(1, 0, 0, 0, 5'h11)});
        drain(0);
        base = nflits;
        send_word({mkf(1, 1, 0, 1, 5'h01), mkf(1, 0, 0, 1, 5'h02), mkf(1, 0, 0, 1, 5'h03), mkf(1, 0, 1, 1, 5'h04)});
        send_word({mkf(1, 1, 1, 0, 5'h09), 27'h0});
        for (int k = 0; k < 6; k++) tick();
        check("t3_stall_cnt", nflits - base, 2);
        check("t3_pending", exp_q.size(), 3);
        credit_in[1] = 1'b1;
        tick();
        check("t3_no_bypass", got_v, 0);
        tick();
        check("t3_flit3", got_v, 1);
        tick();
        check("t3_stall_again", got_v, 0);
        credit_in[1] = 1'b1;
        tick();
        check("t3_no_bypass2", got_v, 0);
        tick();
        check("t3_flit4", got_v, 1);
        tick();
        check("t3_vc0_after", got_v, 1);
        check("t3_vc0_vc", got_f[5], 0);
        return_all();

        // Credit return and emit on the same VC in the same cycle
        send_word({mkf(1, 1, 0, 0, 5'h01), mkf(1, 0, 0, 0, 5'h02), mkf(1, 0, 0, 0, 5'h03), mkf(1, 0, 1, 0, 5'h04)});
        send_word({mkf(1, 1, 0, 0, 5'h05), mkf(1, 0, 1, 0, 5'h06), 18'h0});
        send_word({mkf(1, 1, 1, 0, 5'h07), 27'h0});
        drain(0);
        check("t4_credit_one", dut.credit[0], BD - outstanding[0]);
        valid_in = 1'b1;
        data_in  = {mkf(1, 1, 1, 0, 5'h08), 27'h0};
        tick();
        credit_in[0] = 1'b1;
        tick();
        check("t4_emit", got_v, 1);
        check("t4_credit_held", dut.credit[0], BD - outstanding[0]);
        return_all();

        // Backpressure with randomized words and credit returns
        for (int i = 0; i < 20; i++) words[i] = rand_word(i < 3);
        wi = 0;
        saw_full = 0;
        for (int k = 0; k < 2000 && wi < 20; k++) begin
            valid_in = 1'b1;
            data_in  = words[wi];
            if (!ready_out) saw_full++;
            for (int v = 0; v < 2; v++)
                credit_in[v] = (outstanding[v] > 0) && ($urandom_range(0, 1) == 1);
            step(a);
            if (a) wi++;
        end
        check("t5_words", wi, 20);
        check("t5_backpressure", saw_full > 0, 1);
        drain(1);
        return_all();

        // Reset mid-packet
        base = nflits;
        send_word({mkf(1, 1, 0, 0, 5'h01), mkf(1, 0, 0, 0, 5'h02), mkf(1, 0, 0, 0, 5'h03), mkf(1, 0, 1, 0, 5'h04)});
        for (int k = 0; k < 20 && nflits - base < 2; k++) tick();
        check("t6_two_flits", nflits - base, 2);
        rst_n = 1'b0;
        #1;
        check("t6_async_valid", flit_valid_out, 0);
        check("t6_async_flit", flit_out, 0);
        check("t6_ready", ready_out, 1);
        exp_q.delete();
        outstanding[0] = 0;
        outstanding[1] = 0;
        tick();
        rst_n = 1'b1;
        check("t6_credit0", dut.credit[0], BD);
        check("t6_credit1", dut.credit[1], BD);
        base = nflits;
        send_word({mkf(1, 1, 0, 1, 5'h1D), mkf(1, 0, 0, 1, 5'h1E), mkf(1, 0, 0, 1, 5'h1F), mkf(1, 0, 1, 1, 5'h10)});
        drain(0);
        check("t6_next_packet", nflits - base, 4);
        return_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
